// File: rtl/hack_alu_pkg.sv
// Shared definitions for the pipelined Hack ALU.
//   - CTRL bit positions ({zx,nx,zy,ny,f,no}, bit 5 = zx)
//   - Hack "comp" control encodings for the usual operations
//   - ctrl_t: packed view of the 6 control bits
package hack_alu_pkg;

  localparam int unsigned CTRL_W = 6;

  localparam int unsigned ZX_B = 5;
  localparam int unsigned NX_B = 4;
  localparam int unsigned ZY_B = 3;
  localparam int unsigned NY_B = 2;
  localparam int unsigned F_B  = 1;
  localparam int unsigned NO_B = 0;

  localparam logic [CTRL_W-1:0] C_ZERO = 6'b101010;
  localparam logic [CTRL_W-1:0] C_ONE  = 6'b111111;
  localparam logic [CTRL_W-1:0] C_NEG1 = 6'b111010;
  localparam logic [CTRL_W-1:0] C_X    = 6'b001100;
  localparam logic [CTRL_W-1:0] C_Y    = 6'b110000;
  localparam logic [CTRL_W-1:0] C_NOTX = 6'b001101;
  localparam logic [CTRL_W-1:0] C_XP1  = 6'b011111;
  localparam logic [CTRL_W-1:0] C_XPY  = 6'b000010;
  localparam logic [CTRL_W-1:0] C_XMY  = 6'b010011;
  localparam logic [CTRL_W-1:0] C_YMX  = 6'b000111;
  localparam logic [CTRL_W-1:0] C_AND  = 6'b000000;
  localparam logic [CTRL_W-1:0] C_OR   = 6'b010101;

  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } ctrl_t;

endpackage

// File: rtl/hack_alu_pipe_if.sv
// Handshake bundle for hack_alu_pipe.
//   Input side : in_valid, in_ready, x, y, ctrl, in_tag
//   Output side: out_valid, out_ready, out, ng, zr, carry, out_tag
//   master = producer/consumer around the ALU, slave = the ALU itself.
interface hack_alu_pipe_if #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [5:0]       ctrl;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             ng;
  logic             zr;
  logic             carry;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, x, y, ctrl, in_tag, out_ready,
    input  in_ready, out_valid, out, ng, zr, carry, out_tag
  );

  modport slave (
    input  in_valid, x, y, ctrl, in_tag, out_ready,
    output in_ready, out_valid, out, ng, zr, carry, out_tag
  );
endinterface

// File: rtl/hack_alu_core.sv
// Combinational Hack ALU function stage: add/and, optional output negate,
// and the flags derived from the final value.
//   x1, y1 : preprocessed operands (zero/negate already applied)
//   f      : 1 = add, 0 = and
//   no     : negate result
//   out    : result; ng = out msb; zr = out is zero
//   carry  : carry out of the WIDTH-bit add, taken before negation; 0 for and
module hack_alu_core #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] y1,
  input  logic             f,
  input  logic             no,
  output logic [WIDTH-1:0] out,
  output logic             ng,
  output logic             zr,
  output logic             carry
);
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] s;

  always_comb begin
    sum = {1'b0, x1} + {1'b0, y1};
    if (f) begin
      s     = sum[WIDTH-1:0];
      carry = sum[WIDTH];
    end else begin
      s     = x1 & y1;
      carry = 1'b0;
    end
    out = no ? ~s : s;
    ng  = out[WIDTH-1];
    zr  = (out == '0);
  end
endmodule

// File: rtl/hack_alu_pipe.sv
// Two-stage pipelined Hack ALU with valid/ready on both sides.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset; discards anything in flight
//   bus   : hack_alu_pipe_if slave (operands, control, tag in; result,
//           flags, tag out)
// S1 registers the zero/negate-preprocessed operands; S2 registers the
// result from hack_alu_core. in_ready is the only combinational path
// (from out_ready). Operand and result registers load only with valid
// data, so ignored inputs never reach the outputs.
module hack_alu_pipe
  import hack_alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input logic           clk,
  input logic           rst_n,
  hack_alu_pipe_if.slave bus
);
  ctrl_t            c;
  logic             adv1;
  logic             adv2;
  logic [WIDTH-1:0] xz;
  logic [WIDTH-1:0] yz;
  logic [WIDTH-1:0] x1_d;
  logic [WIDTH-1:0] y1_d;

  logic             s1_v;
  logic [WIDTH-1:0] s1_x;
  logic [WIDTH-1:0] s1_y;
  logic             s1_f;
  logic             s1_no;
  logic [TAG_W-1:0] s1_tag;

  logic [WIDTH-1:0] c_out;
  logic             c_ng;
  logic             c_zr;
  logic             c_carry;

  always_comb begin
    adv2         = !bus.out_valid || bus.out_ready;
    adv1         = !s1_v || adv2;
    bus.in_ready = adv1;
    c            = ctrl_t'(bus.ctrl);
    xz           = c.zx ? '0 : bus.x;
    x1_d         = c.nx ? ~xz : xz;
    yz           = c.zy ? '0 : bus.y;
    y1_d         = c.ny ? ~yz : yz;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v   <= 1'b0;
      s1_x   <= '0;
      s1_y   <= '0;
      s1_f   <= 1'b0;
      s1_no  <= 1'b0;
      s1_tag <= '0;
    end else if (adv1) begin
      s1_v <= bus.in_valid;
      if (bus.in_valid) begin
        s1_x   <= x1_d;
        s1_y   <= y1_d;
        s1_f   <= c.f;
        s1_no  <= c.no;
        s1_tag <= bus.in_tag;
      end
    end
  end

  hack_alu_core #(.WIDTH(WIDTH)) u_core (
    .x1    (s1_x),
    .y1    (s1_y),
    .f     (s1_f),
    .no    (s1_no),
    .out   (c_out),
    .ng    (c_ng),
    .zr    (c_zr),
    .carry (c_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out       <= '0;
      bus.ng        <= 1'b0;
      bus.zr        <= 1'b0;
      bus.carry     <= 1'b0;
      bus.out_tag   <= '0;
    end else if (adv2) begin
      bus.out_valid <= s1_v;
      if (s1_v) begin
        bus.out     <= c_out;
        bus.ng      <= c_ng;
        bus.zr      <= c_zr;
        bus.carry   <= c_carry;
        bus.out_tag <= s1_tag;
      end
    end
  end
endmodule

// File: tb/tb_hack_alu_pipe.sv
module tb_hack_alu_pipe;
  import hack_alu_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hack_alu_pipe_if #(.WIDTH(16), .TAG_W(4)) bus ();
  hack_alu_pipe_if #(.WIDTH(8),  .TAG_W(4)) b8 ();

  hack_alu_pipe #(.WIDTH(16), .TAG_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  hack_alu_pipe #(.WIDTH(8),  .TAG_W(4)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));

  typedef struct {
    logic [15:0] out;
    logic        ng;
    logic        zr;
    logic        carry;
    logic [3:0]  tag;
    int unsigned acc;
  } exp_t;

  exp_t        sb[$];
  int unsigned pops[$];
  int          ncmp = 0;
  int          nfail = 0;
  int unsigned cyc = 0;
  bit          chk_lat = 1'b0;
  bit          rnd_ready = 1'b0;

  logic [5:0] ops [12] = '{C_ZERO, C_ONE, C_NEG1, C_X, C_Y, C_NOTX,
                           C_XP1, C_XPY, C_XMY, C_YMX, C_AND, C_OR};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: Hack semantics of each comp code, carry from the add it implies.
  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                 input logic [5:0] c, input logic [3:0] tag);
    exp_t e;
    logic [15:0] r;
    logic        cy;
    r  = '0;
    cy = 1'b0;
    case (c)
      C_ZERO: r = 16'h0000;
      C_ONE:  begin r = 16'h0001; cy = 1'b1; end
      C_NEG1: r = 16'hFFFF;
      C_X:    r = x;
      C_Y:    r = y;
      C_NOTX: r = ~x;
      C_XP1:  begin r = x + 16'd1; cy = (x != 16'hFFFF); end
      C_XPY:  {cy, r} = {1'b0, x} + {1'b0, y};
      C_XMY:  begin r = x - y; cy = (y > x); end
      C_YMX:  begin r = y - x; cy = (x > y); end
      C_AND:  r = x & y;
      C_OR:   r = x | y;
      default: r = 16'hDEAD;
    endcase
    e.out   = r;
    e.ng    = r[15];
    e.zr    = (r == 16'h0000);
    e.carry = cy;
    e.tag   = tag;
    e.acc   = 0;
    return e;
  endfunction

  // Output monitor: scoreboard pop on each transfer; hold check while stalled.
  logic        stalled = 1'b0;
  logic [15:0] h_out;
  logic [6:0]  h_rest;
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_out", {16'h0, bus.out}, {16'h0, h_out});
        chk("stall_flags_tag", {25'h0, bus.ng, bus.zr, bus.carry, bus.out_tag}, {25'h0, h_rest});
      end
      if (bus.out_valid && bus.out_ready) begin
        ncmp++;
        assert (sb.size() != 0) else begin
          nfail++;
          $error("FAIL unexpected_output: observed tag %h expected none", bus.out_tag);
        end
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("out", {16'h0, bus.out}, {16'h0, e.out});
          chk("flags", {29'h0, bus.ng, bus.zr, bus.carry}, {29'h0, e.ng, e.zr, e.carry});
          chk("tag", {28'h0, bus.out_tag}, {28'h0, e.tag});
          if (chk_lat) chk("latency", cyc, e.acc + 2);
          pops.push_back(cyc);
        end
      end
      stalled = bus.out_valid && !bus.out_ready;
      h_out   = bus.out;
      h_rest  = {bus.ng, bus.zr, bus.carry, bus.out_tag};
    end
  end

  always @(posedge clk) begin
    if (rnd_ready) begin
      #1;
      bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic push(input logic [15:0] x, input logic [15:0] y,
                      input logic [5:0] c, input logic [3:0] tag);
    exp_t e;
    int unsigned n;
    bus.in_valid = 1'b1;
    bus.x        = x;
    bus.y        = y;
    bus.ctrl     = c;
    bus.in_tag   = tag;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.in_ready) break;
    end
    chk("push_accept", {31'h0, n < 200}, 32'h1);
    e     = model(x, y, c, tag);
    e.acc = cyc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.x        = 16'($urandom);
    bus.y        = 16'($urandom);
    bus.ctrl     = 6'($urandom);
    bus.in_tag   = 4'($urandom);
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int unsigned n = 0; n < 500 && sb.size() != 0; n++) @(posedge clk);
    #1;
    chk("drain_empty", sb.size(), 0);
  endtask

  function automatic logic [15:0] rnd_operand();
    logic [15:0] edges [4] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};
    if ($urandom_range(0, 7) == 0) return edges[$urandom_range(0, 3)];
    return 16'($urandom);
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.x         = '0;
    bus.y         = '0;
    bus.ctrl      = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    b8.in_valid   = 1'b0;
    b8.x          = '0;
    b8.y          = '0;
    b8.ctrl       = '0;
    b8.in_tag     = '0;
    b8.out_ready  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("reset_out", {16'h0, bus.out}, 32'h0);
    chk("reset_flags_tag", {25'h0, bus.ng, bus.zr, bus.carry, bus.out_tag}, 32'h0);
    chk("reset_in_ready", {31'h0, bus.in_ready}, 32'h1);
    rst_n = 1'b1;
    idle(1);

    // Directed arithmetic cases, full-rate consumer, latency checked.
    bus.out_ready = 1'b1;
    chk_lat = 1'b1;
    push(16'h1234, 16'h4321, C_XPY, 4'd1);
    drain();
    push(16'h1234, 16'h4321, C_XMY,  4'd2);
    push(16'h1234, 16'h4321, C_AND,  4'd3);
    push(16'h1234, 16'h4321, C_OR,   4'd4);
    push(16'h1234, 16'h4321, C_ZERO, 4'd5);
    push(16'h1234, 16'h4321, C_NEG1, 4'd6);
    push(16'hFFFF, 16'h0001, C_XPY,  4'd7);
    drain();

    // Eight back-to-back ops: each result exactly two cycles after accept.
    pops.delete();
    for (int i = 0; i < 8; i++)
      push(rnd_operand(), rnd_operand(), ops[$urandom_range(0, 11)], 4'(i));
    drain();
    chk("b2b_count", pops.size(), 8);
    if (pops.size() == 8) chk("b2b_span", pops[7] - pops[0], 7);
    chk_lat = 1'b0;

    // Stall with both stages full, then release.
    bus.out_ready = 1'b0;
    push(16'h0003, 16'h0004, C_XPY, 4'd1);
    push(16'h0010, 16'h0001, C_XMY, 4'd2);
    bus.in_valid = 1'b1;
    bus.x        = 16'h00F0;
    bus.y        = 16'h0F00;
    bus.ctrl     = C_OR;
    bus.in_tag   = 4'd3;
    repeat (3) begin
      @(negedge clk);
      chk("full_in_ready", {31'h0, bus.in_ready}, 32'h0);
    end
    @(posedge clk);
    #1;
    pops.delete();
    bus.out_ready = 1'b1;
    push(16'h00F0, 16'h0F00, C_OR, 4'd3);
    drain();
    chk("stall_release_count", pops.size(), 3);
    if (pops.size() == 3) begin
      chk("stall_release_gap1", pops[1] - pops[0], 1);
      chk("stall_release_gap2", pops[2] - pops[1], 1);
    end

    // Random consumer backpressure and producer gaps.
    rnd_ready = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      push(rnd_operand(), rnd_operand(), ops[i % 12], 4'(i));
    end
    rnd_ready = 1'b0;
    @(posedge clk);
    #2;
    bus.out_ready = 1'b1;
    drain();

    // Reset with two ops in flight: nothing comes out afterwards.
    bus.out_ready = 1'b0;
    push(16'h1111, 16'h2222, C_XPY, 4'd9);
    push(16'h3333, 16'h4444, C_AND, 4'd10);
    chk("pre_reset_valid", {31'h0, bus.out_valid}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("rst_out", {16'h0, bus.out}, 32'h0);
    chk("rst_flags_tag", {25'h0, bus.ng, bus.zr, bus.carry, bus.out_tag}, 32'h0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("no_stale", {31'h0, bus.out_valid}, 32'h0);
    end
    @(posedge clk);
    #1;

    // 8-bit instance: signed overflow without carry.
    b8.out_ready = 1'b1;
    b8.x         = 8'h7F;
    b8.y         = 8'h01;
    b8.ctrl      = C_XPY;
    b8.in_tag    = 4'd5;
    b8.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    b8.in_valid = 1'b0;
    begin
      int unsigned n;
      for (n = 0; n < 10; n++) begin
        @(negedge clk);
        if (b8.out_valid) break;
      end
      chk("w8_valid", {31'h0, b8.out_valid}, 32'h1);
    end
    chk("w8_out", {24'h0, b8.out}, 32'h80);
    chk("w8_flags", {29'h0, b8.ng, b8.zr, b8.carry}, {29'h0, 3'b100});
    chk("w8_tag", {28'h0, b8.out_tag}, 32'h5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
